// File: rtl/otter_pkg.sv
// Shared definitions for the OTTER multicycle control unit: FSM states,
// opcode/funct3 constants and the PC-source select encoding used by the PC mux.
package otter_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0]  F3_PRIV  = 3'b000;
    localparam logic [2:0]  F3_CSRRW = 3'b001;
    localparam logic [11:0] IMM_MRET = 12'h302;

    localparam logic [2:0] PC_SRC_PC4    = 3'd0;
    localparam logic [2:0] PC_SRC_JALR   = 3'd1;
    localparam logic [2:0] PC_SRC_BRANCH = 3'd2;
    localparam logic [2:0] PC_SRC_JAL    = 3'd3;
    localparam logic [2:0] PC_SRC_MTVEC  = 3'd4;
    localparam logic [2:0] PC_SRC_MEPC   = 3'd5;

endpackage

// File: rtl/otter_branch_cond.sv
// Branch-taken evaluation from funct3 and the rs1/rs2 compare flags.
// Reserved funct3 values (010, 011) never take the branch.
module otter_branch_cond
    import otter_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       br_eq_i,
    input  logic       br_lt_i,
    input  logic       br_ltu_i,
    output logic       taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o = br_eq_i;
            F3_BNE:  taken_o = ~br_eq_i;
            F3_BLT:  taken_o = br_lt_i;
            F3_BGE:  taken_o = ~br_lt_i;
            F3_BLTU: taken_o = br_ltu_i;
            F3_BGEU: taken_o = ~br_ltu_i;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/otter_cu_fsm.sv
// OTTER multicycle control FSM: INIT -> FETCH -> EXEC [-> WB] [-> INTR] -> FETCH.
// Interrupt entry and mret are only present when OTTER_CU_INTR_EN is defined.
module otter_cu_fsm
    import otter_pkg::*;
#(
    parameter int SEL_W = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             INTR,
    input  logic             MIE,
    input  logic [31:0]      IR,
    input  logic             BR_EQ,
    input  logic             BR_LT,
    input  logic             BR_LTU,
    output logic             PC_WE,
    output logic [SEL_W-1:0] PC_SOURCE,
    output logic             RF_WE,
    output logic             MEM_RDEN1,
    output logic             MEM_RDEN2,
    output logic             MEM_WE2,
    output logic             CSR_WE,
    output logic             INT_TAKEN,
    output logic             MRET_EXEC
);

    state_e     state_q, state_d;
    logic [2:0] pc_src;
    logic       br_taken;
    logic       intr_go;
    logic       is_mret;
    logic       unused_bits;

    wire [6:0] opcode = IR[6:0];
    wire [2:0] funct3 = IR[14:12];

    assign unused_bits = &{1'b0, INTR, MIE, IR};

    otter_branch_cond u_branch_cond (
        .funct3_i (funct3),
        .br_eq_i  (BR_EQ),
        .br_lt_i  (BR_LT),
        .br_ltu_i (BR_LTU),
        .taken_o  (br_taken)
    );

`ifdef OTTER_CU_INTR_EN
    assign intr_go = INTR & MIE;
    assign is_mret = (funct3 == F3_PRIV) && (IR[31:20] == IMM_MRET);
`else
    assign intr_go = 1'b0;
    assign is_mret = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ST_INIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        PC_WE     = 1'b0;
        pc_src    = PC_SRC_PC4;
        RF_WE     = 1'b0;
        MEM_RDEN1 = 1'b0;
        MEM_RDEN2 = 1'b0;
        MEM_WE2   = 1'b0;
        CSR_WE    = 1'b0;
        INT_TAKEN = 1'b0;
        MRET_EXEC = 1'b0;

        case (state_q)
            ST_INIT: state_d = ST_FETCH;

            ST_FETCH: begin
                MEM_RDEN1 = 1'b1;
                state_d   = ST_EXEC;
            end

            ST_EXEC: begin
                // Everything but a load retires here; the load overrides below.
                PC_WE   = 1'b1;
                state_d = intr_go ? ST_INTR : ST_FETCH;
                case (opcode)
                    OPC_LOAD: begin
                        PC_WE     = 1'b0;
                        MEM_RDEN2 = 1'b1;
                        state_d   = ST_WB;
                    end
                    OPC_STORE: MEM_WE2 = 1'b1;
                    OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: RF_WE = 1'b1;
                    OPC_JAL: begin
                        RF_WE  = 1'b1;
                        pc_src = PC_SRC_JAL;
                    end
                    OPC_JALR: begin
                        RF_WE  = 1'b1;
                        pc_src = PC_SRC_JALR;
                    end
                    OPC_BRANCH: pc_src = br_taken ? PC_SRC_BRANCH : PC_SRC_PC4;
                    OPC_SYSTEM: begin
                        if (funct3 == F3_CSRRW) begin
                            CSR_WE = 1'b1;
                            RF_WE  = 1'b1;
                        end else if (is_mret) begin
                            MRET_EXEC = 1'b1;
                            pc_src    = PC_SRC_MEPC;
                        end
                    end
                    default: ;
                endcase
            end

            ST_WB: begin
                RF_WE   = 1'b1;
                PC_WE   = 1'b1;
                state_d = intr_go ? ST_INTR : ST_FETCH;
            end

            ST_INTR: begin
                PC_WE   = 1'b1;
                pc_src  = PC_SRC_MTVEC;
`ifdef OTTER_CU_INTR_EN
                INT_TAKEN = 1'b1;
`endif
                state_d = ST_FETCH;
            end

            default: state_d = ST_INIT;
        endcase
    end

    assign PC_SOURCE = SEL_W'(pc_src);

endmodule
